// File: rtl/arg_max_core.sv
// -----------------------------------------------------------------------------
// arg_max_core
//
// Frame-based complex arg-max. Collects buffer_length complex samples (xi, xq),
// computes each sample's power xi^2 + xq^2 at full precision, and reports the
// largest power of the frame (its most significant out_max_bits bits) together
// with the 0-based position of that sample in the frame. Ties keep the earliest
// position. Intended to sit behind a correlation pipeline to locate its peak.
//
// Ports
//   clk            in   1             rising-edge clock
//   reset          in   1             synchronous, active-high reset
//   m_axis_tvalid  in   1             input sample valid
//   xi             in   i_bits        signed in-phase sample
//   xq             in   q_bits        signed quadrature sample
//   s_axis_tready  out  1             block can accept a sample
//   m_axis_tready  in   1             downstream accepts the result
//   out_max        out  out_max_bits  MS bits of the frame's peak power
//   index          out  index_bits    0-based frame position of the peak
//   s_axis_tvalid  out  1             result valid
//
// Operation
//   COLLECT : s_axis_tready=1. Each accepted sample updates a running max.
//             Accepting the last sample of the frame registers the result and
//             moves to RESULT on the next cycle (one clock of latency).
//   RESULT  : s_axis_tvalid=1, inputs ignored, outputs held until the
//             downstream handshake, after which the block returns to COLLECT.
// -----------------------------------------------------------------------------
module arg_max_core #(
  parameter int buffer_length = 5,   // samples per frame, >= 2
  parameter int index_bits    = 3,   // 2**index_bits >= buffer_length
  parameter int out_max_bits  = 5,   // reported MS bits of peak power
  parameter int i_bits        = 12,  // signed width of xi
  parameter int q_bits        = 12   // signed width of xq
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     m_axis_tvalid,
  input  logic signed [i_bits-1:0] xi,
  input  logic signed [q_bits-1:0] xq,
  output logic                     s_axis_tready,
  input  logic                     m_axis_tready,
  output logic [out_max_bits-1:0]  out_max,
  output logic [index_bits-1:0]    index,
  output logic                     s_axis_tvalid
);

  // Full-precision power width: the larger squared term plus one bit for the
  // sum, so xi^2 + xq^2 can never overflow.
  localparam int SQ_I_BITS = 2 * i_bits;
  localparam int SQ_Q_BITS = 2 * q_bits;
  localparam int P         = ((SQ_I_BITS > SQ_Q_BITS) ? SQ_I_BITS : SQ_Q_BITS) + 1;

  localparam logic [index_bits-1:0] LAST_POS = index_bits'(buffer_length - 1);

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    RESULT  = 1'b1
  } state_t;

  state_t state, state_next;

  // ---------------------------------------------------------------------------
  // Power computation (purely combinational on the current input sample)
  // ---------------------------------------------------------------------------
  logic signed [SQ_I_BITS-1:0] xi_ext, sq_i;
  logic signed [SQ_Q_BITS-1:0] xq_ext, sq_q;
  logic        [P-1:0]         power;

  // Sign-extend before multiplying so the product is computed at full width.
  assign xi_ext = {{i_bits{xi[i_bits-1]}}, xi};
  assign xq_ext = {{q_bits{xq[q_bits-1]}}, xq};
  assign sq_i   = xi_ext * xi_ext;
  assign sq_q   = xq_ext * xq_ext;

  // Squares are never negative, so zero-extension turns them into unsigned
  // magnitudes of the full power width.
  assign power = {{(P - SQ_I_BITS){1'b0}}, sq_i} + {{(P - SQ_Q_BITS){1'b0}}, sq_q};

  // ---------------------------------------------------------------------------
  // Running max tracking
  // ---------------------------------------------------------------------------
  logic [index_bits-1:0] count;
  logic [P-1:0]          run_max;
  logic [index_bits-1:0] run_idx;

  logic                  accept;
  logic                  last_sample;
  logic                  take_new;
  logic [P-1:0]          cand_max;
  logic [index_bits-1:0] cand_idx;

  assign accept      = m_axis_tvalid & s_axis_tready;
  assign last_sample = (count == LAST_POS);

  // The first sample of a frame always loads, so an all-zero frame reports
  // position 0. Afterwards only a strictly larger power wins, which keeps the
  // earliest position on ties.
  assign take_new = (count == '0) || (power > run_max);
  assign cand_max = take_new ? power : run_max;
  assign cand_idx = take_new ? count : run_idx;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking (<=) so every register samples the
  // pre-edge values of the others; blocking here would create order-dependent
  // simulation that does not match the synthesized flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= COLLECT;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: state_next gets a default before the case so every path assigns it;
  // a missing assignment on any branch would infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      COLLECT: if (accept && last_sample) state_next = RESULT;
      RESULT:  if (m_axis_tready)         state_next = COLLECT;
      default:                            state_next = COLLECT;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (decoded from the registered state, hence glitch-free)
  // ---------------------------------------------------------------------------
  always_comb begin
    s_axis_tready = 1'b0;
    s_axis_tvalid = 1'b0;
    case (state)
      COLLECT: s_axis_tready = 1'b1;
      RESULT:  s_axis_tvalid = 1'b1;
      default: s_axis_tready = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  // accept is only possible in COLLECT, so RESULT leaves everything untouched
  // and the reported result stays stable under backpressure and afterwards,
  // until the next frame completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      run_max <= '0;
      run_idx <= '0;
      out_max <= '0;
      index   <= '0;
    end else if (accept) begin
      if (last_sample) begin
        out_max <= cand_max[P-1 -: out_max_bits];
        index   <= cand_idx;
        count   <= '0;
        run_max <= '0;
        run_idx <= '0;
      end else begin
        count   <= count + index_bits'(1);
        run_max <= cand_max;
        run_idx <= cand_idx;
      end
    end
  end

endmodule

// File: tb/tb_arg_max_core.sv
// -----------------------------------------------------------------------------
// tb_arg_max_core
//
// Self-checking bench for arg_max_core. Stimulus tasks push the expected
// (index, out_max) of each frame into a scoreboard queue as the frame's last
// sample is driven; the result is popped and compared when the DUT raises
// s_axis_tvalid. Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_arg_max_core;

  localparam int BL  = 5;
  localparam int IB  = 3;
  localparam int OMB = 5;
  localparam int XB  = 12;
  localparam int P   = 2 * XB + 1;

  typedef int frame_t [BL];

  typedef struct {
    logic [IB-1:0]  idx;
    logic [OMB-1:0] mx;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 m_axis_tvalid = 1'b0;
  logic signed [XB-1:0] xi = '0;
  logic signed [XB-1:0] xq = '0;
  logic                 s_axis_tready;
  logic                 m_axis_tready = 1'b1;
  logic [OMB-1:0]       out_max;
  logic [IB-1:0]        index;
  logic                 s_axis_tvalid;

  int checks   = 0;
  int failures = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  arg_max_core #(
    .buffer_length(BL),
    .index_bits   (IB),
    .out_max_bits (OMB),
    .i_bits       (XB),
    .q_bits       (XB)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .m_axis_tvalid(m_axis_tvalid),
    .xi           (xi),
    .xq           (xq),
    .s_axis_tready(s_axis_tready),
    .m_axis_tready(m_axis_tready),
    .out_max      (out_max),
    .index        (index),
    .s_axis_tvalid(s_axis_tvalid)
  );

  // Reference: full-precision power, first sample loads, strict > afterwards.
  function automatic exp_t model(input frame_t fi, input frame_t fq);
    logic [P-1:0] best, p;
    int           bi;
    exp_t         r;
    best = '0;
    bi   = 0;
    for (int i = 0; i < BL; i++) begin
      p = P'(fi[i] * fi[i] + fq[i] * fq[i]);
      if (i == 0 || p > best) begin
        best = p;
        bi   = i;
      end
    end
    r.idx = IB'(bi);
    r.mx  = best[P-1 -: OMB];
    return r;
  endfunction

  // Drives n samples of a frame; with gaps, a junk invalid cycle follows each.
  // Leaves m_axis_tvalid high on the last sample (caller drops it).
  task automatic drive_frame(input frame_t fi, input frame_t fq, input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      m_axis_tvalid = 1'b1;
      xi = XB'(fi[i]);
      xq = XB'(fq[i]);
      if (i == BL - 1) sb.push_back(model(fi, fq));
      if (gaps && i != n - 1) begin
        @(negedge clk);
        m_axis_tvalid = 1'b0;
        xi = XB'($urandom);
        xq = XB'($urandom);
      end
    end
  endtask

  // Waits (bounded) for the result, compares it against the scoreboard, and
  // when m_axis_tready is high also checks that s_axis_tvalid is a 1-clk pulse.
  task automatic expect_result(input string name, input bit check_pulse);
    int   n;
    exp_t e;
    @(negedge clk);
    m_axis_tvalid = 1'b0;
    n = 0;
    while (!s_axis_tvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (s_axis_tvalid !== 1'b1 || n != 0) begin
      failures++;
      $display("FAIL %s latency: tvalid=%b after %0d extra clks, required tvalid=1 after 0", name, s_axis_tvalid, n);
    end
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s scoreboard: empty queue, required one pending result", name);
    end else begin
      e = sb.pop_front();
      checks++;
      if (index !== e.idx) begin
        failures++;
        $display("FAIL %s index: got %0d required %0d", name, index, e.idx);
      end
      checks++;
      if (out_max !== e.mx) begin
        failures++;
        $display("FAIL %s out_max: got %0d required %0d", name, out_max, e.mx);
      end
    end
    checks++;
    if (s_axis_tready !== 1'b0) begin
      failures++;
      $display("FAIL %s tready_in_result: got %b required 0", name, s_axis_tready);
    end
    if (check_pulse) begin
      @(negedge clk);
      checks++;
      if (s_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b1) begin
        failures++;
        $display("FAIL %s pulse: tvalid=%b tready=%b required tvalid=0 tready=1", name, s_axis_tvalid, s_axis_tready);
      end
    end
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (s_axis_tready !== 1'b1 || s_axis_tvalid !== 1'b0 || out_max !== '0 || index !== '0) begin
      failures++;
      $display("FAIL %s: tready=%b tvalid=%b out_max=%0d index=%0d required 1 0 0 0",
               name, s_axis_tready, s_axis_tvalid, out_max, index);
    end
  endtask

  frame_t f1_i = '{0, 100, -2048, 2047, 5};
  frame_t f1_q = '{0, 100, -2048, 0, 5};
  frame_t f2_i = '{0, 1500, 3, 1500, 1};
  frame_t f2_q = '{0, 1500, 3, -1500, 1};
  frame_t fz   = '{0, 0, 0, 0, 0};

  task automatic test_reset();
    reset = 1'b1;
    m_axis_tvalid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_idle("reset_state");
  endtask

  task automatic test_peak();
    m_axis_tready = 1'b1;
    drive_frame(f1_i, f1_q, BL, 1'b0);
    expect_result("peak", 1'b1);
  endtask

  task automatic test_tie();
    drive_frame(f2_i, f2_q, BL, 1'b0);
    expect_result("tie", 1'b1);
  endtask

  task automatic test_all_zero();
    drive_frame(fz, fz, BL, 1'b0);
    expect_result("all_zero", 1'b1);
  endtask

  task automatic test_backpressure();
    m_axis_tready = 1'b0;
    drive_frame(f1_i, f1_q, BL, 1'b0);
    expect_result("bp_frame", 1'b0);
    for (int c = 0; c < 10; c++) begin
      m_axis_tvalid = 1'b1;
      xi = XB'($urandom);
      xq = XB'($urandom);
      @(negedge clk);
      checks++;
      if (s_axis_tready !== 1'b0 || s_axis_tvalid !== 1'b1 || index !== 3'd2 || out_max !== 5'd8) begin
        failures++;
        $display("FAIL bp_hold cycle %0d: tready=%b tvalid=%b index=%0d out_max=%0d required 0 1 2 8",
                 c, s_axis_tready, s_axis_tvalid, index, out_max);
      end
    end
    m_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    @(negedge clk);
    checks++;
    if (s_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b1 || index !== 3'd2 || out_max !== 5'd8) begin
      failures++;
      $display("FAIL bp_release: tvalid=%b tready=%b index=%0d out_max=%0d required 0 1 2 8",
               s_axis_tvalid, s_axis_tready, index, out_max);
    end
    drive_frame(f2_i, f2_q, BL, 1'b0);
    expect_result("bp_next_frame", 1'b1);
  endtask

  task automatic test_gaps();
    drive_frame(f1_i, f1_q, BL, 1'b1);
    expect_result("gaps", 1'b1);
  endtask

  task automatic test_back_to_back();
    drive_frame(f2_i, f2_q, BL, 1'b0);
    expect_result("b2b_first", 1'b1);
    drive_frame(f1_i, f1_q, BL, 1'b0);
    expect_result("b2b_second", 1'b1);
  endtask

  task automatic test_mid_frame_reset();
    drive_frame(f1_i, f1_q, 3, 1'b0);
    @(negedge clk);
    m_axis_tvalid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_idle("mid_reset_state");
    drive_frame(f2_i, f2_q, BL, 1'b0);
    expect_result("after_reset", 1'b1);
  endtask

  initial begin
    test_reset();
    test_peak();
    test_tie();
    test_all_zero();
    test_backpressure();
    test_gaps();
    test_back_to_back();
    test_mid_frame_reset();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d results pending, required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
